unified_mem_arbiter: RTL and testbench
======================================

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2, memory read latency in cycles (legal 1..15).
REQ-002 SHALL have parameter STARVE_MAX, default 4, maximum consecutive data grants while fetch waits (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port if_req  input  1  fetch request, held with if_addr until if_valid.
REQ-006 SHALL have port if_addr  input  32  fetch byte address.
REQ-007 SHALL have port if_rdata  output  32  fetched instruction word.
REQ-008 SHALL have port if_valid  output  1  one-cycle pulse: if_rdata valid, fetch complete.
REQ-009 SHALL have port if_stall  output  1  fetch stage hold.
REQ-010 SHALL have port d_req  input  1  data request, held with d_we/d_addr/d_wdata until d_valid.
REQ-011 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port d_addr  input  32  data byte address.
REQ-013 SHALL have port d_wdata  input  32  store data.
REQ-014 SHALL have port d_rdata  output  32  load data.
REQ-015 SHALL have port d_valid  output  1  one-cycle pulse: load data valid or store done.
REQ-016 SHALL have port d_stall  output  1  memory stage hold.
REQ-017 SHALL have ports mem_en  output  1, mem_we  output  1, mem_addr  output  32, mem_wdata  output  32  single-port unified memory command.
REQ-018 SHALL have port mem_rdata  input  32  valid exactly LAT cycles after the cycle with mem_en=1, mem_we=0.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: if d_req or if_req, SHALL register the winner's command (addr, we, wdata) and grant owner, then go ISSUE; else stay IDLE.
REQ-021 Arbitration SHALL give data priority, except fetch wins when if_req=1 and starve counter == STARVE_MAX.
REQ-022 Starve counter SHALL increment (saturating at STARVE_MAX) on each data grant with if_req=1, and clear on fetch grant or on data grant with if_req=0.
REQ-023 ISSUE: SHALL drive mem_en=1 for exactly one cycle with registered mem_we/mem_addr/mem_wdata; next state WAIT for reads, RESP for writes.
REQ-024 WAIT: SHALL count LAT cycles, capture mem_rdata on the LAT-th edge into the owner's rdata register, then go RESP.
REQ-025 RESP: SHALL pulse owner's valid for one cycle, then go IDLE; the non-owner's valid SHALL stay 0.
REQ-026 Read latency request-sample to valid pulse SHALL be LAT+2 cycles; store SHALL be 2 cycles.
REQ-027 if_rdata/d_rdata SHALL hold their last captured value until the next read for that port; stores SHALL not change d_rdata.
REQ-028 if_stall SHALL equal if_req & ~if_valid; d_stall SHALL equal d_req & ~d_valid (combinational).
REQ-029 Outside ISSUE, mem_en and mem_we SHALL be 0; mem_addr/mem_wdata SHALL hold their last values.
REQ-030 Requests arriving outside IDLE SHALL be sampled only on the next IDLE cycle; no request SHALL be dropped while held.
REQ-031 Request deasserted before its grant SHALL be ignored; deassertion after grant SHALL not abort the transaction.

Reset
REQ-032 On rst=0, SHALL asynchronously force state IDLE, starve counter 0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0, if_valid=0, d_valid=0.
REQ-033 Reset mid-transaction SHALL abandon it with no valid pulse; the first post-reset grant SHALL follow normal arbitration.

Verification
REQ-034 LAT=2, if_req only, if_addr=0x10, mem returns 0x00A00093 -> mem_en one cycle, if_valid pulse 4 cycles after request sample, if_rdata=0x00A00093.
REQ-035 if_req and d_req (load 0x200) same cycle -> data granted first; fetch granted in next IDLE; d_valid precedes if_valid.
REQ-036 Store d_addr=0x40, d_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, addr/data as given; d_valid 2 cycles after sample; d_rdata unchanged.
REQ-037 STARVE_MAX=4, d_req held through 5 load transactions with if_req=1 -> 4 data grants, then fetch grant, then data resumes.
REQ-038 Load in WAIT state, rst=0 for one cycle -> outputs at reset values immediately, no d_valid; re-issued load completes normally.
REQ-039 LAT=1 and LAT=15 sweeps -> read valid at LAT+2 cycles, mem_en never asserted twice per transaction.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port memory.
// Data wins by default; a starve counter forces a fetch grant after STARVE_MAX data grants.
module unified_mem_arbiter #(
  parameter int unsigned LAT        = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LatLast   = 4'(LAT - 1);
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = data port owns the transaction
  logic [3:0]  starve_q, starve_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        d_valid_q, d_valid_d;
  logic        grant_fetch;

  assign grant_fetch = if_req & (~d_req | (starve_q == StarveMax));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    wait_cnt_d  = wait_cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (d_req || if_req) begin
          // Command is loaded on the grant edge so it appears on the bus during StIssue.
          mem_en_d = 1'b1;
          state_d  = StIssue;
          if (grant_fetch) begin
            owner_d    = 1'b0;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
            starve_d   = 4'd0;
          end else begin
            owner_d     = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (!if_req) begin
              starve_d = 4'd0;
            end else if (starve_q != StarveMax) begin
              starve_d = starve_q + 4'd1;
            end
          end
        end
      end
      StIssue: begin
        wait_cnt_d = 4'd0;
        if (mem_we_q) begin
          state_d   = StResp;
          d_valid_d = owner_q;
          if_valid_d = ~owner_q;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (wait_cnt_q == LatLast) begin
          state_d = StResp;
          if (owner_q) begin
            d_rdata_d = mem_rdata;
            d_valid_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      starve_q    <= 4'd0;
      wait_cnt_q  <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign d_stall   = d_req & ~d_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: instance 0 (LAT=2) carries the main tests,
// instances 1 (LAT=1) and 2 (LAT=15) are only released for the latency sweep.
module tb_unified_mem_arbiter;

  localparam int NI = 3;

  function automatic int lat_of(input int k);
    return (k == 1) ? 1 : (k == 2) ? 15 : 2;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h00A00093;
    return (a ^ 32'hA5C3_0000) + 32'h11;
  endfunction

  typedef struct {
    string       name;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } sb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_v;
  logic          if_req, d_req, d_we;
  logic [31:0]   if_addr, d_addr, d_wdata;
  logic [NI-1:0] if_valid_v, if_stall_v, d_valid_v, d_stall_v, mem_en_v, mem_we_v;
  logic [31:0]   if_rdata_v [NI];
  logic [31:0]   d_rdata_v  [NI];
  logic [31:0]   mem_addr_v [NI];
  logic [31:0]   mem_wdata_v[NI];
  logic [31:0]   mem_rdata_v[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned L = (g == 1) ? 1 : (g == 2) ? 15 : 2;
    unified_mem_arbiter #(.LAT(L), .STARVE_MAX(4)) u_dut (
      .clk      (clk),
      .rst      (rst_v[g]),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata_v[g]),
      .if_valid (if_valid_v[g]),
      .if_stall (if_stall_v[g]),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata_v[g]),
      .d_valid  (d_valid_v[g]),
      .d_stall  (d_stall_v[g]),
      .mem_en   (mem_en_v[g]),
      .mem_we   (mem_we_v[g]),
      .mem_addr (mem_addr_v[g]),
      .mem_wdata(mem_wdata_v[g]),
      .mem_rdata(mem_rdata_v[g])
    );
  end

  // Memory model: read data is valid only in the cycle exactly LAT after the mem_en cycle.
  logic [15:0] pv [NI];
  logic [31:0] pd [NI][16];
  int          en_cnt [NI];
  cmd_t        cmd_log[$];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      pv[k]    <= {pv[k][14:0], mem_en_v[k] & ~mem_we_v[k]};
      pd[k][0] <= mem_word(mem_addr_v[k]);
      for (int j = 1; j < 16; j++) pd[k][j] <= pd[k][j-1];
      if (mem_en_v[k]) en_cnt[k] <= en_cnt[k] + 1;
    end
    if (mem_en_v[0]) cmd_log.push_back('{mem_we_v[0], mem_addr_v[0], mem_wdata_v[0]});
  end

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      mem_rdata_v[k] = pv[k][lat_of(k)-1] ? pd[k][lat_of(k)-1] : 32'hBAD0_BAD0;
    end
  end

  int          total = 0;
  int          bad   = 0;
  sb_t         sb_q[$];
  logic [31:0] last_if, last_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] log_addr(input int i);
    return (cmd_log.size() > i) ? cmd_log[i].addr : 32'hFFFF_FFFF;
  endfunction

  // Advance to the next falling edge and run the instance-0 scoreboard monitor.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    chk("if_stall", 32'(if_stall_v[0]), 32'(if_req & ~if_valid_v[0]));
    chk("d_stall", 32'(d_stall_v[0]), 32'(d_req & ~d_valid_v[0]));
    chk("mem_we_outside_issue", 32'(mem_we_v[0] & ~mem_en_v[0]), 32'd0);
    if (rst_v[0] && (if_valid_v[0] || d_valid_v[0])) begin
      chk("single_valid", 32'(if_valid_v[0] & d_valid_v[0]), 32'd0);
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: actual if_valid=%b d_valid=%b required none",
                 if_valid_v[0], d_valid_v[0]);
      end else begin
        e = sb_q.pop_front();
        chk("valid_port", 32'(d_valid_v[0]), 32'(e.is_d));
        chk("resp_rdata", e.is_d ? d_rdata_v[0] : if_rdata_v[0], e.rdata);
      end
    end
  endtask

  task automatic run_txn(input int k, input vec_t v);
    int   lat;
    int   en0;
    bit   done;
    cmd_t c;
    tick();
    en0     = en_cnt[k];
    if_addr = v.addr;
    d_addr  = v.addr;
    d_we    = v.we;
    d_wdata = v.wdata;
    if (v.is_d) d_req = 1'b1;
    else if_req = 1'b1;
    if (k == 0) sb_q.push_back('{v.is_d, v.exp_rdata});
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      done = v.is_d ? d_valid_v[k] : if_valid_v[k];
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    chk({v.name, "_lat"}, done ? 32'(lat) : 32'hFFFF_FFFF, 32'(v.exp_lat));
    chk({v.name, "_mem_en_count"}, 32'(en_cnt[k] - en0), 32'd1);
    if (k != 0) begin
      chk({v.name, "_rdata"}, v.is_d ? d_rdata_v[k] : if_rdata_v[k], v.exp_rdata);
    end else begin
      c = (cmd_log.size() > 0) ? cmd_log[$] : '{1'bx, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      chk({v.name, "_mem_addr"}, c.addr, v.addr);
      chk({v.name, "_mem_we"}, 32'(c.we), 32'(v.we));
      if (v.we) chk({v.name, "_mem_wdata"}, c.wdata, v.wdata);
      if (!v.we) begin
        if (v.is_d) last_d = v.exp_rdata;
        else last_if = v.exp_rdata;
      end
      chk({v.name, "_if_rdata_hold"}, if_rdata_v[0], last_if);
      chk({v.name, "_d_rdata_hold"}, d_rdata_v[0], last_d);
    end
  endtask

  vec_t tbl[8];

  initial begin
    int   idx, nd, lat, en0;
    bit   done;
    vec_t v;
    logic [31:0] starve_addrs[6];

    tbl[0] = '{"fetch_10",  1'b0, 1'b0, 32'h10,       32'h0,        32'h00A00093,            4};
    tbl[1] = '{"load_200",  1'b1, 1'b0, 32'h200,      32'h0,        mem_word(32'h200),       4};
    tbl[2] = '{"store_40",  1'b1, 1'b1, 32'h40,       32'hDEADBEEF, mem_word(32'h200),       2};
    tbl[3] = '{"fetch_14",  1'b0, 1'b0, 32'h14,       32'h0,        mem_word(32'h14),        4};
    tbl[4] = '{"load_1000", 1'b1, 1'b0, 32'h1000,     32'h0,        mem_word(32'h1000),      4};
    tbl[5] = '{"store_44",  1'b1, 1'b1, 32'h44,       32'h12345678, mem_word(32'h1000),      2};
    tbl[6] = '{"fetch_top", 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        mem_word(32'hFFFFFFFC),  4};
    tbl[7] = '{"load_0",    1'b1, 1'b0, 32'h0,        32'h0,        mem_word(32'h0),         4};

    rst_v   = '0;
    if_req  = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    if_addr = '0;
    d_addr  = '0;
    d_wdata = '0;
    last_if = '0;
    last_d  = '0;
    repeat (20) @(negedge clk);

    chk("rst_mem_en", 32'(mem_en_v[0]), 32'd0);
    chk("rst_mem_we", 32'(mem_we_v[0]), 32'd0);
    chk("rst_mem_addr", mem_addr_v[0], 32'd0);
    chk("rst_mem_wdata", mem_wdata_v[0], 32'd0);
    chk("rst_if_rdata", if_rdata_v[0], 32'd0);
    chk("rst_d_rdata", d_rdata_v[0], 32'd0);
    chk("rst_if_valid", 32'(if_valid_v[0]), 32'd0);
    chk("rst_d_valid", 32'(d_valid_v[0]), 32'd0);
    rst_v[0] = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(0, tbl[i]);

    // Simultaneous fetch and load: data first, fetch on the next idle cycle.
    tick();
    idx     = cmd_log.size();
    if_addr = 32'h30;
    d_addr  = 32'h200;
    d_we    = 1'b0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    sb_q.push_back('{1'b1, mem_word(32'h200)});
    sb_q.push_back('{1'b0, mem_word(32'h30)});
    for (int n = 0; n < 60 && (if_req || d_req); n++) begin
      tick();
      if (d_valid_v[0]) d_req = 1'b0;
      if (if_valid_v[0]) if_req = 1'b0;
    end
    chk("conc_done", 32'({if_req, d_req}), 32'd0);
    if_req = 1'b0;
    d_req  = 1'b0;
    chk("conc_first_addr", log_addr(idx), 32'h200);
    chk("conc_second_addr", log_addr(idx + 1), 32'h30);
    last_d  = mem_word(32'h200);
    last_if = mem_word(32'h30);

    // Starvation: four data grants, then the waiting fetch, then data again.
    tick();
    idx     = cmd_log.size();
    if_addr = 32'h80;
    d_addr  = 32'h100;
    d_we    = 1'b0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    starve_addrs = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h80, 32'h110};
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back('{(i != 4), mem_word(starve_addrs[i])});
    end
    nd = 0;
    for (int n = 0; n < 200 && (if_req || d_req); n++) begin
      tick();
      if (d_valid_v[0]) begin
        nd++;
        if (nd == 5) d_req = 1'b0;
        else d_addr = 32'h100 + 32'(4 * nd);
      end
      if (if_valid_v[0]) if_req = 1'b0;
    end
    chk("starve_done", 32'({if_req, d_req}), 32'd0);
    if_req = 1'b0;
    d_req  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("starve_grant%0d_addr", i), log_addr(idx + i), starve_addrs[i]);
    end
    last_d  = mem_word(32'h110);
    last_if = mem_word(32'h80);

    // Reset while a load sits in the wait state, then let the held request re-issue.
    tick();
    en0    = en_cnt[0];
    d_addr = 32'h300;
    d_we   = 1'b0;
    d_req  = 1'b1;
    sb_q.push_back('{1'b1, mem_word(32'h300)});
    tick();
    tick();
    rst_v[0] = 1'b0;
    #1;
    chk("midrst_mem_en", 32'(mem_en_v[0]), 32'd0);
    chk("midrst_mem_addr", mem_addr_v[0], 32'd0);
    chk("midrst_mem_wdata", mem_wdata_v[0], 32'd0);
    chk("midrst_if_rdata", if_rdata_v[0], 32'd0);
    chk("midrst_d_rdata", d_rdata_v[0], 32'd0);
    chk("midrst_d_valid", 32'(d_valid_v[0]), 32'd0);
    last_if = '0;
    tick();
    chk("midrst_no_valid", 32'(d_valid_v[0] | if_valid_v[0]), 32'd0);
    rst_v[0] = 1'b1;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      done = d_valid_v[0];
    end
    d_req = 1'b0;
    chk("reissue_lat", done ? 32'(lat) : 32'hFFFF_FFFF, 32'd4);
    chk("reissue_mem_en_count", 32'(en_cnt[0] - en0), 32'd2);
    chk("reissue_d_rdata", d_rdata_v[0], mem_word(32'h300));
    chk("reissue_if_rdata_hold", if_rdata_v[0], last_if);

    // Latency sweep on the LAT=1 and LAT=15 instances.
    for (int k = 1; k < NI; k++) begin
      tick();
      rst_v[0] = 1'b0;
      rst_v[k] = 1'b1;
      v = '{$sformatf("sweep%0d_fetch", k), 1'b0, 1'b0, 32'h10, 32'h0, 32'h00A00093,
            lat_of(k) + 2};
      run_txn(k, v);
      v = '{$sformatf("sweep%0d_load", k), 1'b1, 1'b0, 32'h208, 32'h0, mem_word(32'h208),
            lat_of(k) + 2};
      run_txn(k, v);
      v = '{$sformatf("sweep%0d_store", k), 1'b1, 1'b1, 32'h48, 32'hCAFEF00D,
            mem_word(32'h208), 2};
      run_txn(k, v);
      rst_v[k] = 1'b0;
    end

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: actual=%0d entries required=0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
